// File: rtl/sipo_frame_rx_if.sv
// rtl/sipo_frame_rx_if.sv - control, serial input and output-handshake bundle for sipo_frame_rx
interface sipo_frame_rx_if #(
  parameter int DW = 32
);
  logic          enable;
  logic          sipo_start;
  logic          sipo_bit_valid;
  logic          sipo_serial_in;
  logic          sipo_ovr_clr;
  logic          data_ready;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          sipo_frame_done_tick;
  logic          sipo_overrun;
  logic          sipo_busy;

  modport master (
    output enable, sipo_start, sipo_bit_valid, sipo_serial_in, sipo_ovr_clr, data_ready,
    input  data_out, data_valid, sipo_frame_done_tick, sipo_overrun, sipo_busy
  );

  modport slave (
    input  enable, sipo_start, sipo_bit_valid, sipo_serial_in, sipo_ovr_clr, data_ready,
    output data_out, data_valid, sipo_frame_done_tick, sipo_overrun, sipo_busy
  );
endinterface

// File: rtl/sipo_frame_rx.sv
// rtl/sipo_frame_rx.sv - MSB-first serial frame receiver with valid/ready output register
module sipo_frame_rx #(
  parameter int DW = 32,
  parameter int CW = 6
) (
  input  logic           clk,
  input  logic           reset,
  sipo_frame_rx_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] shift_q, shift_d;
  logic [DW-1:0] data_q;
  logic          valid_q;
  logic          tick_q;
  logic          ovr_q;
  logic          last_bit;
  logic          store;
  logic          drop;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    last_bit = 1'b0;
    if (bus.enable) begin
      unique case (state_q)
        IDLE: begin
          if (bus.sipo_start) begin
            state_d = SHIFT;
            cnt_d   = '0;
          end
        end
        SHIFT: begin
          // A start inside a frame restarts it; the bit on that cycle is dropped.
          if (bus.sipo_start) begin
            cnt_d = '0;
          end else if (bus.sipo_bit_valid) begin
            shift_d = {shift_q[DW-2:0], bus.sipo_serial_in};
            if (cnt_q == CW'(DW - 1)) begin
              last_bit = 1'b1;
              state_d  = IDLE;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign store = last_bit && (!valid_q || bus.data_ready);
  assign drop  = last_bit && valid_q && !bus.data_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      tick_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      tick_q  <= store;
      if (store) begin
        data_q  <= shift_d;
        valid_q <= 1'b1;
      end else if (bus.data_ready) begin
        valid_q <= 1'b0;
      end
      // Set has priority over clear so a drop on the clearing cycle is not lost.
      if (drop) begin
        ovr_q <= 1'b1;
      end else if (bus.sipo_ovr_clr) begin
        ovr_q <= 1'b0;
      end
    end
  end

  assign bus.data_out             = data_q;
  assign bus.data_valid           = valid_q;
  assign bus.sipo_frame_done_tick = tick_q;
  assign bus.sipo_overrun         = ovr_q;
  assign bus.sipo_busy            = (state_q == SHIFT);
endmodule

// File: tb/tb_sipo_frame_rx.sv
// tb/tb_sipo_frame_rx.sv - self-checking bench for sipo_frame_rx
module tb_sipo_frame_rx;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  sipo_frame_rx_if #(.DW(32)) bus ();

  sipo_frame_rx #(.DW(32), .CW(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: collects bits in a queue and forms the word arithmetically.
  bit          m_active;
  bit          mq[$];
  logic [31:0] m_data;
  bit          m_valid;
  bit          m_tick;
  bit          m_ovr;

  typedef struct {
    logic [31:0] word;
    bit          ready;
    bit          ready_last;
    bit          clr;
    int          pre_bits;
    bit          gaps;
    logic [31:0] exp_data;
    bit          exp_valid;
    bit          exp_tick;
    bit          exp_ovr;
  } vec_t;

  vec_t tbl[6];

  task automatic model_reset();
    m_active = 1'b0;
    mq.delete();
    m_data   = '0;
    m_valid  = 1'b0;
    m_tick   = 1'b0;
    m_ovr    = 1'b0;
  endtask

  task automatic model_edge();
    bit          store = 1'b0;
    bit          drop  = 1'b0;
    logic [31:0] w;
    if (bus.enable) begin
      if (bus.sipo_start) begin
        m_active = 1'b1;
        mq.delete();
      end else if (m_active && bus.sipo_bit_valid) begin
        mq.push_back(bus.sipo_serial_in);
        if (mq.size() == 32) begin
          w = '0;
          foreach (mq[i]) w = w * 2 + 32'(mq[i]);
          m_active = 1'b0;
          mq.delete();
          if (!m_valid || bus.data_ready) begin
            store  = 1'b1;
            m_data = w;
          end else begin
            drop = 1'b1;
          end
        end
      end
    end
    if (store) m_valid = 1'b1;
    else if (bus.data_ready) m_valid = 1'b0;
    m_tick = store;
    if (drop) m_ovr = 1'b1;
    else if (bus.sipo_ovr_clr) m_ovr = 1'b0;
  endtask

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_model();
    cmp("data_out", bus.data_out, m_data);
    cmp("data_valid", 32'(bus.data_valid), 32'(m_valid));
    cmp("tick", 32'(bus.sipo_frame_done_tick), 32'(m_tick));
    cmp("overrun", 32'(bus.sipo_overrun), 32'(m_ovr));
    cmp("busy", 32'(bus.sipo_busy), 32'(m_active));
  endtask

  task automatic cyc(bit st, bit bv, bit si, bit en, bit rdy, bit clr);
    bus.sipo_start     = st;
    bus.sipo_bit_valid = bv;
    bus.sipo_serial_in = si;
    bus.enable         = en;
    bus.data_ready     = rdy;
    bus.sipo_ovr_clr   = clr;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic check_all_zero(string name);
    cmp({name, "_data"}, bus.data_out, 32'h0);
    cmp({name, "_valid"}, 32'(bus.data_valid), 32'h0);
    cmp({name, "_tick"}, 32'(bus.sipo_frame_done_tick), 32'h0);
    cmp({name, "_ovr"}, 32'(bus.sipo_overrun), 32'h0);
    cmp({name, "_busy"}, 32'(bus.sipo_busy), 32'h0);
  endtask

  task automatic send_frame(vec_t v);
    bit rdy;
    rdy = v.ready_last ? 1'b0 : v.ready;
    if (v.pre_bits > 0) begin
      cyc(1, 0, 0, 1, rdy, 0);
      for (int i = 0; i < v.pre_bits; i++) cyc(0, 1, 1'($urandom), 1, rdy, 0);
    end
    cyc(1, 0, 0, 1, rdy, v.clr);
    for (int i = 0; i < 32; i++) begin
      if (v.gaps && (i % 2 == 1)) cyc(0, 0, 1'($urandom), 1, rdy, 0);
      if (v.gaps && i == 16) begin
        for (int k = 0; k < 5; k++) cyc(k == 2, 1, 1'($urandom), 0, rdy, 0);
      end
      cyc(0, 1, v.word[31-i], 1, (i == 31 && v.ready_last) ? 1'b1 : rdy, 0);
    end
    cmp("tbl_data", bus.data_out, v.exp_data);
    cmp("tbl_valid", 32'(bus.data_valid), 32'(v.exp_valid));
    cmp("tbl_tick", 32'(bus.sipo_frame_done_tick), 32'(v.exp_tick));
    cmp("tbl_ovr", 32'(bus.sipo_overrun), 32'(v.exp_ovr));
    cyc(0, 0, 0, 1, rdy, 0);
    cmp("tick_one_cycle", 32'(bus.sipo_frame_done_tick), 32'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    tbl[0] = '{32'hA5C3_0F96, 1, 0, 0, 0,  0, 32'hA5C3_0F96, 1, 1, 0};
    tbl[1] = '{32'h0000_0001, 0, 0, 0, 0,  0, 32'h0000_0001, 1, 1, 0};
    tbl[2] = '{32'h0000_0002, 0, 0, 0, 0,  0, 32'h0000_0001, 1, 0, 1};
    tbl[3] = '{32'h0000_0003, 0, 1, 1, 0,  0, 32'h0000_0003, 1, 1, 0};
    tbl[4] = '{32'hDEAD_BEEF, 1, 0, 0, 10, 0, 32'hDEAD_BEEF, 1, 1, 0};
    tbl[5] = '{32'h5A5A_1234, 1, 0, 0, 0,  1, 32'h5A5A_1234, 1, 1, 0};

    bus.enable = 0; bus.sipo_start = 0; bus.sipo_bit_valid = 0;
    bus.sipo_serial_in = 0; bus.sipo_ovr_clr = 0; bus.data_ready = 0;
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;

    foreach (tbl[i]) send_frame(tbl[i]);

    // Reset after 20 bits discards the frame and clears outputs without a clock edge.
    cyc(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 1, 1'($urandom), 1, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all_zero("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    send_frame('{32'hC0FF_EE11, 1, 0, 0, 0, 0, 32'hC0FF_EE11, 1, 1, 0});

    // Back-to-back frames: the next start arrives on the cycle after the last bit.
    for (int f = 0; f < 2; f++) begin
      logic [31:0] w;
      w = $urandom;
      cyc(1, 0, 0, 1, 1, 0);
      for (int i = 0; i < 32; i++) cyc(0, 1, w[31-i], 1, 1, 0);
      cmp("b2b_data", bus.data_out, w);
    end

    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7, 1'($urandom),
          $urandom_range(0, 9) != 0, 1'($urandom), $urandom_range(0, 19) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
